titan_mem_arbiter: RTL and testbench

- Two-master to one-slave memory bus arbiter for the Titan core.
- Shares a single Wishbone-style memory port between two requesters:
  - the instruction-fetch port (IF stage, read-only);
  - the data port (MEM stage, driven by the decoder's load/store mem_flags).
- Round-robin on simultaneous requests, one transfer per grant, per-transfer watchdog timeout returning a bus error.

---
 rtl/titan_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_titan_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/titan_mem_arbiter.sv
// titan_mem_arbiter: shares one Wishbone-style slave port between the
// instruction-fetch master and the data master. Round-robin on ties, one
// transfer per grant with an idle cycle between grants, and a per-transfer
// watchdog that ends a stalled transfer with a bus error.
module titan_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_WIDTH       = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] iport_addr_i,
    input  logic        iport_cyc_i,
    input  logic        iport_stb_i,
    output logic [31:0] iport_dat_o,
    output logic        iport_ack_o,
    output logic        iport_err_o,
    input  logic [31:0] dport_addr_i,
    input  logic [31:0] dport_dat_i,
    input  logic [3:0]  dport_sel_i,
    input  logic        dport_we_i,
    input  logic        dport_cyc_i,
    input  logic        dport_stb_i,
    output logic [31:0] dport_dat_o,
    output logic        dport_ack_o,
    output logic        dport_err_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_dat_o,
    output logic [3:0]  mem_sel_o,
    output logic        mem_we_o,
    output logic        mem_cyc_o,
    output logic        mem_stb_o,
    input  logic [31:0] mem_dat_i,
    input  logic        mem_ack_i,
    input  logic        mem_err_i,
    output logic [1:0]  owner_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        IPORT = 2'b01,
        DPORT = 2'b10
    } state_t;

    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TO_WIDTH-1:0] TO_LAST =
        TO_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t              state_q, state_d;
    state_t              last_q, last_d;
    logic [TO_WIDTH-1:0] cnt_q, cnt_d;

    logic req_ip, req_dp;
    logic own_cyc, own_stb;
    logic wd_fire, xfer_end;

    // Decode requests, the owner's bus qualifiers, watchdog firing and transfer end
    always_comb begin
        req_ip  = iport_cyc_i & iport_stb_i;
        req_dp  = dport_cyc_i & dport_stb_i;
        own_cyc = 1'b0;
        own_stb = 1'b0;
        case (state_q)
            IPORT: begin
                own_cyc = iport_cyc_i;
                own_stb = iport_stb_i;
            end
            DPORT: begin
                own_cyc = dport_cyc_i;
                own_stb = dport_stb_i;
            end
            default: ;
        endcase
        // A slave response in the last allowed cycle wins over the watchdog
        wd_fire  = WD_EN && (state_q != IDLE) && own_cyc && !mem_ack_i && !mem_err_i
                   && (cnt_q == TO_LAST);
        xfer_end = (state_q != IDLE) && (mem_ack_i || mem_err_i || !own_cyc || wd_fire);
    end

    // Next-state: arbitrate in IDLE, return to IDLE at the end of every transfer
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_ip && req_dp) begin
                    state_d = (last_q == IPORT) ? DPORT : IPORT;
                end else if (req_ip) begin
                    state_d = IPORT;
                end else if (req_dp) begin
                    state_d = DPORT;
                end
            end
            default: begin
                if (xfer_end) begin
                    state_d = IDLE;
                    last_d  = state_q;
                    cnt_d   = '0;
                end else if (WD_EN) begin
                    cnt_d = cnt_q + TO_WIDTH'(1);
                end
            end
        endcase
    end

    // State, last-owner and watchdog registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= IPORT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Slave-side mux from the owner and response routing back to the owner only
    always_comb begin
        mem_addr_o  = '0;
        mem_dat_o   = '0;
        mem_sel_o   = '0;
        mem_we_o    = 1'b0;
        mem_cyc_o   = 1'b0;
        mem_stb_o   = 1'b0;
        iport_ack_o = 1'b0;
        iport_err_o = 1'b0;
        dport_ack_o = 1'b0;
        dport_err_o = 1'b0;
        timeout_o   = wd_fire;
        owner_o     = state_q;
        case (state_q)
            IPORT: begin
                mem_addr_o  = iport_addr_i;
                mem_sel_o   = 4'hF;
                mem_cyc_o   = own_cyc & ~wd_fire;
                mem_stb_o   = own_stb & ~wd_fire;
                iport_ack_o = mem_ack_i & ~mem_err_i;
                iport_err_o = mem_err_i | wd_fire;
            end
            DPORT: begin
                mem_addr_o  = dport_addr_i;
                mem_dat_o   = dport_dat_i;
                mem_sel_o   = dport_sel_i;
                mem_we_o    = dport_we_i;
                mem_cyc_o   = own_cyc & ~wd_fire;
                mem_stb_o   = own_stb & ~wd_fire;
                dport_ack_o = mem_ack_i & ~mem_err_i;
                dport_err_o = mem_err_i | wd_fire;
            end
            default: ;
        endcase
        // Read data is a shared pass-through, held at zero while in reset
        iport_dat_o = rst_i ? '0 : mem_dat_i;
        dport_dat_o = rst_i ? '0 : mem_dat_i;
    end

endmodule

// File: tb/tb_titan_mem_arbiter.sv
// tb_titan_mem_arbiter: directed scenarios followed by randomized traffic,
// each cycle checked against a transaction-rule reference model.
module tb_titan_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] iport_addr_i, iport_dat_o;
    logic        iport_cyc_i, iport_stb_i, iport_ack_o, iport_err_o;
    logic [31:0] dport_addr_i, dport_dat_i, dport_dat_o;
    logic [3:0]  dport_sel_i;
    logic        dport_we_i, dport_cyc_i, dport_stb_i, dport_ack_o, dport_err_o;
    logic [31:0] mem_addr_o, mem_dat_o, mem_dat_i;
    logic [3:0]  mem_sel_o;
    logic        mem_we_o, mem_cyc_o, mem_stb_o, mem_ack_i, mem_err_i;
    logic [1:0]  owner_o;
    logic        timeout_o;

    titan_mem_arbiter #(.TIMEOUT_CYCLES(TO), .TO_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .iport_addr_i(iport_addr_i), .iport_cyc_i(iport_cyc_i), .iport_stb_i(iport_stb_i),
        .iport_dat_o(iport_dat_o), .iport_ack_o(iport_ack_o), .iport_err_o(iport_err_o),
        .dport_addr_i(dport_addr_i), .dport_dat_i(dport_dat_i), .dport_sel_i(dport_sel_i),
        .dport_we_i(dport_we_i), .dport_cyc_i(dport_cyc_i), .dport_stb_i(dport_stb_i),
        .dport_dat_o(dport_dat_o), .dport_ack_o(dport_ack_o), .dport_err_o(dport_err_o),
        .mem_addr_o(mem_addr_o), .mem_dat_o(mem_dat_o), .mem_sel_o(mem_sel_o),
        .mem_we_o(mem_we_o), .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o),
        .mem_dat_i(mem_dat_i), .mem_ack_i(mem_ack_i), .mem_err_i(mem_err_i),
        .owner_o(owner_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Staged stimulus, applied to the DUT on the falling edge
    logic        s_ic, s_is, s_dc, s_ds, s_dwe, s_ack, s_err;
    logic [31:0] s_ia, s_da, s_dd, s_rd;
    logic [3:0]  s_dsel;

    // Reference model: 0 = nobody, 1 = fetch port, 2 = data port
    int  m_owner, m_last, m_cnt;
    int  grants[$];
    bit  e_iresp, e_dresp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_i(input logic c, input logic s, input logic [31:0] a);
        s_ic = c; s_is = s; s_ia = a;
    endtask

    task automatic set_d(input logic c, input logic s, input logic we,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
        s_dc = c; s_ds = s; s_dwe = we; s_da = a; s_dd = d; s_dsel = sel;
    endtask

    task automatic set_slv(input logic ack, input logic err, input logic [31:0] rd);
        s_ack = ack; s_err = err; s_rd = rd;
    endtask

    task automatic apply();
        iport_cyc_i = s_ic; iport_stb_i = s_is; iport_addr_i = s_ia;
        dport_cyc_i = s_dc; dport_stb_i = s_ds; dport_we_i = s_dwe;
        dport_addr_i = s_da; dport_dat_i = s_dd; dport_sel_i = s_dsel;
        mem_ack_i = s_ack; mem_err_i = s_err; mem_dat_i = s_rd;
    endtask

    // One bus cycle: apply staged inputs, check every output, advance the model
    task automatic tick();
        logic [31:0] e_addr, e_wdat;
        logic [3:0]  e_sel;
        bit e_we, e_cyc, e_stb, e_iack, e_ierr, e_dack, e_derr, e_to;
        bit oc, os, fire, done;
        @(negedge clk);
        apply();
        #1;
        e_addr = '0; e_wdat = '0; e_sel = '0;
        e_we = 0; e_cyc = 0; e_stb = 0;
        e_iack = 0; e_ierr = 0; e_dack = 0; e_derr = 0; e_to = 0;
        fire = 0; done = 0;
        if (m_owner != 0) begin
            oc   = (m_owner == 1) ? s_ic : s_dc;
            os   = (m_owner == 1) ? s_is : s_ds;
            fire = oc && !s_ack && !s_err && (m_cnt == TO - 1);
            e_cyc = oc && !fire;
            e_stb = os && !fire;
            if (m_owner == 1) begin
                e_addr = s_ia; e_sel = 4'hF;
                e_iack = s_ack && !s_err;
                e_ierr = s_err || fire;
            end else begin
                e_addr = s_da; e_wdat = s_dd; e_sel = s_dsel; e_we = s_dwe;
                e_dack = s_ack && !s_err;
                e_derr = s_err || fire;
            end
            e_to = fire;
            done = s_ack || s_err || !oc || fire;
        end
        chk("owner",     32'(owner_o),     32'(m_owner));
        chk("mem_cyc",   32'(mem_cyc_o),   32'(e_cyc));
        chk("mem_stb",   32'(mem_stb_o),   32'(e_stb));
        chk("mem_addr",  mem_addr_o,       e_addr);
        chk("mem_dat",   mem_dat_o,        e_wdat);
        chk("mem_sel",   32'(mem_sel_o),   32'(e_sel));
        chk("mem_we",    32'(mem_we_o),    32'(e_we));
        chk("iport_ack", 32'(iport_ack_o), 32'(e_iack));
        chk("iport_err", 32'(iport_err_o), 32'(e_ierr));
        chk("dport_ack", 32'(dport_ack_o), 32'(e_dack));
        chk("dport_err", 32'(dport_err_o), 32'(e_derr));
        chk("timeout",   32'(timeout_o),   32'(e_to));
        chk("iport_dat", iport_dat_o,      s_rd);
        chk("dport_dat", dport_dat_o,      s_rd);
        e_iresp = e_iack || e_ierr;
        e_dresp = e_dack || e_derr;
        if (m_owner == 0) begin
            if ((s_ic && s_is) && (s_dc && s_ds)) m_owner = (m_last == 1) ? 2 : 1;
            else if (s_ic && s_is)                m_owner = 1;
            else if (s_dc && s_ds)                m_owner = 2;
            if (m_owner != 0) grants.push_back(m_owner);
            m_cnt = 0;
        end else if (done) begin
            m_last  = m_owner;
            m_owner = 0;
            m_cnt   = 0;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_last = 1; m_cnt = 0;
    endtask

    initial begin
        bit i_act, d_act;
        int n_i, n_d;

        // Reset with live requests and read data present: everything must read 0
        rst = 1'b1;
        set_i(1, 1, 32'h0000_0040);
        set_d(1, 1, 1, 32'h0000_0080, 32'h1111_2222, 4'hF);
        set_slv(1, 0, 32'h1234_5678);
        apply();
        #12;
        chk("rst_owner",     32'(owner_o),     32'd0);
        chk("rst_mem_cyc",   32'(mem_cyc_o),   32'd0);
        chk("rst_mem_addr",  mem_addr_o,       32'd0);
        chk("rst_iport_ack", 32'(iport_ack_o), 32'd0);
        chk("rst_dport_ack", 32'(dport_ack_o), 32'd0);
        chk("rst_iport_dat", iport_dat_o,      32'd0);
        chk("rst_timeout",   32'(timeout_o),   32'd0);
        set_i(0, 0, '0);
        set_d(0, 0, 0, '0, '0, '0);
        set_slv(0, 0, '0);
        @(negedge clk);
        apply();
        rst = 1'b0;
        model_reset();
        tick();

        // Single fetch, slave acks two cycles after the grant
        set_i(1, 1, 32'h0000_0100);
        tick();
        chk("fetch_req_cyc", 32'(mem_cyc_o), 32'd0);
        tick();
        chk("fetch_grant_cyc", 32'(mem_cyc_o), 32'd1);
        chk("fetch_grant_owner", 32'(owner_o), 32'd1);
        tick();
        set_slv(1, 0, 32'h0000_0013);
        tick();
        chk("fetch_ack", 32'(iport_ack_o), 32'd1);
        chk("fetch_dat", iport_dat_o, 32'h0000_0013);
        chk("fetch_dack", 32'(dport_ack_o), 32'd0);
        set_i(0, 0, '0);
        set_slv(0, 0, '0);
        tick();
        chk("fetch_done_owner", 32'(owner_o), 32'd0);

        // Tie: data port wins, mandatory idle, then fetch port
        set_i(1, 1, 32'h0000_0200);
        set_d(1, 1, 1, 32'h0000_2000, 32'hDEAD_BEEF, 4'b0011);
        tick();
        tick();
        chk("tie_owner", 32'(owner_o), 32'd2);
        chk("tie_we", 32'(mem_we_o), 32'd1);
        chk("tie_sel", 32'(mem_sel_o), 32'b0011);
        chk("tie_wdat", mem_dat_o, 32'hDEAD_BEEF);
        set_slv(1, 0, '0);
        tick();
        chk("tie_dack", 32'(dport_ack_o), 32'd1);
        set_d(0, 0, 0, '0, '0, '0);
        set_slv(0, 0, '0);
        tick();
        chk("tie_gap_owner", 32'(owner_o), 32'd0);
        tick();
        chk("tie_second_owner", 32'(owner_o), 32'd1);
        set_slv(1, 0, 32'h0000_0077);
        tick();
        chk("tie_second_ack", 32'(iport_ack_o), 32'd1);

        // Round-robin under continuous contention, slave always acking
        set_i(1, 1, 32'h0000_0300);
        set_d(1, 1, 0, 32'h0000_3000, '0, 4'hF);
        set_slv(1, 0, 32'h0000_0055);
        grants.delete();
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i % 2 == 1) chk("rr_owner", 32'(owner_o), ((i / 2) % 2 == 0) ? 32'd2 : 32'd1);
        end
        n_i = 0; n_d = 0;
        foreach (grants[k]) if (grants[k] == 1) n_i++; else n_d++;
        chk("rr_grants_i", 32'(n_i), 32'd4);
        chk("rr_grants_d", 32'(n_d), 32'd4);

        // Ack and err together: err wins
        set_d(0, 0, 0, '0, '0, '0);
        set_i(1, 1, 32'h0000_0400);
        set_slv(0, 0, '0);
        tick();
        tick();
        set_slv(1, 1, '0);
        tick();
        chk("prec_err", 32'(iport_err_o), 32'd1);
        chk("prec_ack", 32'(iport_ack_o), 32'd0);
        set_i(0, 0, '0);
        set_slv(0, 0, '0);
        tick();
        chk("prec_idle", 32'(owner_o), 32'd0);

        // Watchdog on a data load the slave never answers
        set_d(1, 1, 0, 32'h0000_5000, '0, 4'hF);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_wait_cyc", 32'(mem_cyc_o), 32'd1);
        end
        tick();
        chk("to_fire_err", 32'(dport_err_o), 32'd1);
        chk("to_fire_pulse", 32'(timeout_o), 32'd1);
        chk("to_fire_cyc", 32'(mem_cyc_o), 32'd0);
        set_d(0, 0, 0, '0, '0, '0);
        set_slv(1, 0, 32'h0000_0099);
        tick();
        chk("to_after_owner", 32'(owner_o), 32'd0);
        chk("to_late_ack", 32'(dport_ack_o), 32'd0);
        set_slv(0, 0, '0);
        tick();

        // Reset mid-transfer while the data port owns the bus
        set_d(1, 1, 1, 32'h0000_6000, 32'hCAFE_F00D, 4'hC);
        set_slv(0, 0, 32'hA5A5_A5A5);
        tick();
        tick();
        chk("mid_owner_pre", 32'(owner_o), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_owner", 32'(owner_o), 32'd0);
        chk("mid_rst_cyc", 32'(mem_cyc_o), 32'd0);
        chk("mid_rst_addr", mem_addr_o, 32'd0);
        chk("mid_rst_we", 32'(mem_we_o), 32'd0);
        chk("mid_rst_dat", dport_dat_o, 32'd0);
        set_i(0, 0, '0);
        set_d(0, 0, 0, '0, '0, '0);
        set_slv(0, 0, '0);
        @(negedge clk);
        apply();
        rst = 1'b0;
        model_reset();
        set_i(1, 1, 32'h0000_0700);
        set_d(1, 1, 0, 32'h0000_7000, '0, 4'hF);
        tick();
        tick();
        chk("mid_tie_owner", 32'(owner_o), 32'd2);

        // Randomized traffic: masters hold requests until the model predicts a response
        i_act = 1; d_act = 1;
        for (int n = 0; n < 600; n++) begin
            if (!i_act && $urandom_range(0, 99) < 40) begin
                i_act = 1; s_ia = $urandom;
            end
            if (!d_act && $urandom_range(0, 99) < 40) begin
                d_act = 1; s_da = $urandom; s_dd = $urandom;
                s_dsel = 4'($urandom_range(0, 15)); s_dwe = 1'($urandom_range(0, 1));
            end
            if (i_act && $urandom_range(0, 99) < 3) i_act = 0;
            if (d_act && $urandom_range(0, 99) < 3) d_act = 0;
            s_ic = i_act; s_is = i_act && ($urandom_range(0, 99) < 90);
            s_dc = d_act; s_ds = d_act && ($urandom_range(0, 99) < 90);
            s_ack = ($urandom_range(0, 99) < 30);
            s_err = ($urandom_range(0, 99) < 8);
            s_rd  = $urandom;
            tick();
            if (e_iresp) i_act = 0;
            if (e_dresp) d_act = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
